// File: rtl/itu656_encoder.sv
// rtl/itu656_encoder.sv - BT.656 byte-stream generator from a YCbCr 4:2:2 pixel source
// One byte per clock: EAV, blanking, SAV, then active video pulled from an upstream FIFO.
module itu656_encoder #(
  parameter int H_ACTIVE     = 720,
  parameter int H_TOTAL      = 1716,
  parameter int V_TOTAL      = 525,
  parameter int FIELD2_START = 263,
  parameter int V_BLANK      = 20
) (
  input  logic        iCLK_27,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [15:0] iYCbCr,
  input  logic        iVALID,
  output logic [7:0]  oTD_DATA,
  output logic        oTD_HS,
  output logic        oTD_VS,
  output logic        oFIELD,
  output logic [9:0]  oLINE,
  output logic        oREQ,
  output logic        oUNDERRUN
);
  localparam int BW = $clog2(H_TOTAL);
  localparam int A0 = H_TOTAL - 2 * H_ACTIVE;

  localparam logic [BW-1:0] B_LAST      = BW'(H_TOTAL - 1);
  localparam logic [BW-1:0] B_EAV_END   = BW'(4);
  localparam logic [BW-1:0] B_SAV       = BW'(A0 - 4);
  localparam logic [BW-1:0] B_ACT       = BW'(A0);
  localparam logic [BW-1:0] B_REQ_FIRST = BW'(A0 - 2);
  localparam logic [BW-1:0] B_REQ_LAST  = BW'(H_TOTAL - 4);
  localparam logic [1:0]    SAV_LO      = B_SAV[1:0];
  localparam logic          ACT_LO      = B_ACT[0];
  localparam logic          REQ_LO      = B_REQ_FIRST[0];
  localparam logic [9:0]    L_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]    L_F2        = 10'(FIELD2_START);
  localparam logic [9:0]    L_VB1       = 10'(V_BLANK);
  localparam logic [9:0]    L_VB2       = 10'(FIELD2_START + V_BLANK);

  logic [BW-1:0] b_q, b_d;
  logic [9:0]    line_q, line_d;
  logic          en_q, en_d;
  logic [15:0]   pix_q, pix_d;
  logic [7:0]    data_q, data_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          field_q, field_d;
  logic [9:0]    oline_q, oline_d;
  logic          req_q, req_d;
  logic          und_q, und_d;

  logic       f, v, hx, live, odd_a;
  logic [1:0] code_idx;
  logic [7:0] xy, code, raw, act;

  always_comb begin
    f        = (line_q >= L_F2);
    v        = (line_q < L_VB1) || (f && (line_q < L_VB2));
    hx       = (b_q < B_EAV_END);
    xy       = {1'b1, f, v, hx, v ^ hx, f ^ hx, f ^ v, f ^ v ^ hx};
    code_idx = hx ? b_q[1:0] : (b_q[1:0] - SAV_LO);
    code     = (code_idx == 2'd0) ? 8'hFF : (code_idx == 2'd3) ? xy : 8'h00;
    live     = ~v & en_q;
    odd_a    = b_q[0] ^ ACT_LO;

    // Active bytes: stored pixel when live, otherwise black / blanking level.
    if (live) begin
      raw = odd_a ? pix_q[15:8] : pix_q[7:0];
    end else begin
      raw = odd_a ? 8'h10 : 8'h80;
    end
    act = (raw == 8'h00) ? 8'h01 : (raw == 8'hFF) ? 8'hFE : raw;

    if (hx || ((b_q >= B_SAV) && (b_q < B_ACT))) begin
      data_d = code;
    end else if (b_q < B_SAV) begin
      data_d = b_q[0] ? 8'h10 : 8'h80;
    end else begin
      data_d = act;
    end

    hs_d    = (b_q < B_ACT);
    vs_d    = v;
    field_d = f;
    oline_d = line_q;
    req_d   = live && (b_q >= B_REQ_FIRST) && (b_q <= B_REQ_LAST) && ((b_q[0] ^ REQ_LO) == 1'b0);
    en_d    = (b_q == '0) ? iEN : en_q;

    // The word requested last cycle is captured now; a missing word becomes black.
    pix_d = pix_q;
    und_d = und_q;
    if (req_q) begin
      pix_d = iVALID ? iYCbCr : 16'h1080;
      und_d = und_q | ~iVALID;
    end

    if (b_q == B_LAST) begin
      b_d    = '0;
      line_d = (line_q == L_LAST) ? 10'd0 : line_q + 10'd1;
    end else begin
      b_d    = b_q + 1'b1;
      line_d = line_q;
    end
  end

  always_ff @(posedge iCLK_27 or posedge iRST) begin
    if (iRST) begin
      b_q     <= '0;
      line_q  <= '0;
      en_q    <= 1'b0;
      pix_q   <= 16'h1080;
      data_q  <= 8'h80;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      field_q <= 1'b0;
      oline_q <= '0;
      req_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      b_q     <= b_d;
      line_q  <= line_d;
      en_q    <= en_d;
      pix_q   <= pix_d;
      data_q  <= data_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      field_q <= field_d;
      oline_q <= oline_d;
      req_q   <= req_d;
      und_q   <= und_d;
    end
  end

  assign oTD_DATA  = data_q;
  assign oTD_HS    = hs_q;
  assign oTD_VS    = vs_q;
  assign oFIELD    = field_q;
  assign oLINE     = oline_q;
  assign oREQ      = req_q;
  assign oUNDERRUN = und_q;
endmodule

// File: tb/tb_itu656_encoder.sv
// tb/tb_itu656_encoder.sv - self-checking bench for itu656_encoder
// Full-width lines with a shortened frame; a line/pixel reference model checks every output byte.
module tb_itu656_encoder;
  localparam int H_ACTIVE     = 720;
  localparam int H_TOTAL      = 1716;
  localparam int V_TOTAL      = 12;
  localparam int FIELD2_START = 6;
  localparam int V_BLANK      = 2;
  localparam int A0           = H_TOTAL - 2 * H_ACTIVE;
  localparam int FRAME        = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] ycbcr;
  logic        valid;
  logic [7:0]  td_data;
  logic        td_hs, td_vs, field, req, underrun;
  logic [9:0]  line_no;

  itu656_encoder #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .FIELD2_START(FIELD2_START), .V_BLANK(V_BLANK)
  ) dut (
    .iCLK_27(clk), .iRST(rst), .iEN(en), .iYCbCr(ycbcr), .iVALID(valid),
    .oTD_DATA(td_data), .oTD_HS(td_hs), .oTD_VS(td_vs), .oFIELD(field),
    .oLINE(line_no), .oREQ(req), .oUNDERRUN(underrun)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int mode = 0;

  // reference model state
  int          m_b = 0, m_line = 0, m_req_p = 0;
  bit          m_en = 0, m_und = 0, m_f, m_v, m_live;
  logic [15:0] m_pix [H_ACTIVE];
  logic [7:0]  e_data = 8'h80;
  logic        e_hs = 0, e_vs = 0, e_f = 0, e_req = 0, e_und = 0;
  logic [9:0]  e_line = 0;
  int          out_b = -1, out_line = 0;

  logic [7:0]  cap [H_TOTAL];
  bit          capreq [H_TOTAL];
  logic [7:0]  obs_eav [V_TOTAL];
  logic [7:0]  obs_sav [V_TOTAL];
  bit          obs_f [V_TOTAL];
  bit          obs_v [V_TOTAL];

  typedef struct {
    int         line;
    logic [7:0] eav;
    logic [7:0] sav;
    bit         f;
    bit         v;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkc(input string sig, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s line %0d byte %0d: got %0h expected %0h", sig, out_line, out_b, act, exp);
    end
  endtask

  function automatic logic [7:0] xy(bit f, bit v, bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] model_byte(bit f, bit v, bit live, int b);
    int a, k;
    logic [15:0] w;
    logic [7:0] r;
    if (b < 4) return (b == 0) ? 8'hFF : (b == 3) ? xy(f, v, 1'b1) : 8'h00;
    if (b < A0 - 4) return (b % 2 != 0) ? 8'h10 : 8'h80;
    if (b < A0) begin
      k = b - (A0 - 4);
      return (k == 0) ? 8'hFF : (k == 3) ? xy(f, v, 1'b0) : 8'h00;
    end
    a = b - A0;
    if (!live) return (a % 2 != 0) ? 8'h10 : 8'h80;
    w = m_pix[a / 2];
    r = (a % 2 != 0) ? w[15:8] : w[7:0];
    if (r == 8'h00) return 8'h01;
    if (r == 8'hFF) return 8'hFE;
    return r;
  endfunction

  // Model: decides, per (line, byte), what must appear after this edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b = 0; m_line = 0; m_en = 0; m_und = 0;
      e_data = 8'h80; e_hs = 0; e_vs = 0; e_f = 0; e_line = 0; e_req = 0; e_und = 0;
      out_b = -1; out_line = 0;
    end else begin
      if (e_req) begin
        m_pix[m_req_p] = valid ? ycbcr : 16'h1080;
        if (!valid) m_und = 1;
      end
      if (m_b == 0) m_en = en;
      m_f    = (m_line >= FIELD2_START);
      m_v    = (m_line < V_BLANK) || (m_f && m_line < FIELD2_START + V_BLANK);
      m_live = !m_v && m_en;
      e_data = model_byte(m_f, m_v, m_live, m_b);
      e_hs   = (m_b < A0);
      e_vs   = m_v;
      e_f    = m_f;
      e_line = 10'(m_line);
      e_req  = m_live && (m_b >= A0 - 2) && (m_b <= H_TOTAL - 4) && ((m_b - A0) % 2 == 0);
      m_req_p = (m_b - A0 + 2) / 2;
      e_und  = m_und;
      out_b = m_b;
      out_line = m_line;
      m_b++;
      if (m_b == H_TOTAL) begin
        m_b = 0;
        m_line = (m_line + 1) % V_TOTAL;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chkc("data", td_data, e_data);
    chkc("hs", td_hs, e_hs);
    chkc("vs", td_vs, e_vs);
    chkc("field", field, e_f);
    chkc("line", line_no, e_line);
    chkc("req", req, e_req);
    chkc("underrun", underrun, e_und);
    if (out_b >= 0) begin
      cap[out_b] = td_data;
      capreq[out_b] = req;
      if (out_b == H_TOTAL - 1) begin
        obs_eav[out_line] = cap[3];
        obs_sav[out_line] = cap[A0 - 1];
        obs_f[out_line] = field;
        obs_v[out_line] = td_vs;
      end
    end
  end

  // Pixel source: answers each oREQ according to the current mode; off-sample cycles carry noise.
  initial begin
    ycbcr = 16'h0;
    valid = 1'b0;
    forever begin
      bit samp;
      @(negedge clk);
      samp = req;
      case (mode)
        0: begin ycbcr = samp ? 16'h5A3C : 16'($urandom); valid = samp ? 1'b1 : 1'($urandom); end
        1: begin ycbcr = samp ? 16'hFF00 : 16'($urandom); valid = samp ? 1'b1 : 1'($urandom); end
        3: begin
          ycbcr = samp ? 16'h5A3C : 16'($urandom);
          valid = samp ? (out_b != A0 + 8) : 1'($urandom);
        end
        default: begin ycbcr = 16'($urandom); valid = ($urandom_range(0, 15) != 0); end
      endcase
    end
  end

  task automatic wait_pos(input int l, input int b);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_line == l && out_b == b) && n < 2 * FRAME);
    if (n >= 2 * FRAME) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pos line %0d byte %0d: got timeout expected position reached", l, b);
    end
  endtask

  function automatic int count_reqs();
    int n = 0;
    for (int i = 0; i < H_TOTAL; i++) if (capreq[i]) n++;
    return n;
  endfunction

  function automatic int first_req();
    for (int i = 0; i < H_TOTAL; i++) if (capreq[i]) return i;
    return -1;
  endfunction

  function automatic int last_req();
    for (int i = H_TOTAL - 1; i >= 0; i--) if (capreq[i]) return i;
    return -1;
  endfunction

  function automatic int count_pat(logic [7:0] ev, logic [7:0] od);
    int n = 0;
    for (int a = 0; a < 2 * H_ACTIVE; a++)
      if (cap[A0 + a] == ((a % 2 != 0) ? od : ev)) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] ex [6];
    tbl[0] = '{0,  8'hB6, 8'hAB, 1'b0, 1'b1};
    tbl[1] = '{1,  8'hB6, 8'hAB, 1'b0, 1'b1};
    tbl[2] = '{2,  8'h9D, 8'h80, 1'b0, 1'b0};
    tbl[3] = '{5,  8'h9D, 8'h80, 1'b0, 1'b0};
    tbl[4] = '{6,  8'hF1, 8'hEC, 1'b1, 1'b1};
    tbl[5] = '{7,  8'hF1, 8'hEC, 1'b1, 1'b1};
    tbl[6] = '{8,  8'hDA, 8'hC7, 1'b1, 1'b0};
    tbl[7] = '{11, 8'hDA, 8'hC7, 1'b1, 1'b0};

    rst = 1'b1;
    en = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    chk("reset data", td_data, 8'h80);
    chk("reset hs", td_hs, 1'b0);
    chk("reset req", req, 1'b0);
    chk("reset underrun", underrun, 1'b0);
    chk("reset line", line_no, 10'd0);
    rst = 1'b0;

    wait_pos(0, H_TOTAL - 1);
    ex = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10};
    for (int i = 0; i < 6; i++) chk($sformatf("line0 byte%0d", i), cap[i], ex[i]);
    ex = '{8'hFF, 8'h00, 8'h00, 8'hAB, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) chk($sformatf("line0 sav%0d", i), cap[A0 - 4 + i], ex[i]);
    chk("line0 reqs", count_reqs(), 0);
    en = 1'b1;

    wait_pos(1, H_TOTAL - 1);
    chk("line1 vblank reqs", count_reqs(), 0);
    mode = 0;

    wait_pos(2, H_TOTAL - 1);
    ex = '{8'hFF, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) chk($sformatf("line2 sav%0d", i), cap[A0 - 4 + i], ex[i]);
    chk("line2 active 3C/5A", count_pat(8'h3C, 8'h5A), 2 * H_ACTIVE);
    chk("line2 reqs", count_reqs(), H_ACTIVE);
    chk("line2 first req", first_req(), A0 - 2);
    chk("line2 last req", last_req(), H_TOTAL - 4);
    mode = 1;

    wait_pos(3, H_TOTAL - 1);
    chk("line3 eav xy", cap[3], 8'h9D);
    chk("line3 clamp 01/FE", count_pat(8'h01, 8'hFE), 2 * H_ACTIVE);
    chk("line3 underrun", underrun, 1'b0);
    mode = 3;

    wait_pos(4, H_TOTAL - 1);
    ex = '{8'h3C, 8'h5A, 8'h80, 8'h10, 8'h3C, 8'h5A};
    for (int i = 0; i < 6; i++) chk($sformatf("line4 a%0d", 8 + i), cap[A0 + 8 + i], ex[i]);
    chk("line4 underrun", underrun, 1'b1);
    chk("line4 reqs", count_reqs(), H_ACTIVE);
    mode = 2;

    wait_pos(8, 800);
    en = 1'b0;
    wait_pos(8, H_TOTAL - 1);
    chk("line8 reqs after iEN drop", count_reqs(), H_ACTIVE);
    chk("line8 eav xy", cap[3], 8'hDA);
    chk("line8 sav xy", cap[A0 - 1], 8'hC7);
    chk("line8 field", field, 1'b1);

    wait_pos(9, H_TOTAL - 1);
    chk("line9 reqs disabled", count_reqs(), 0);
    chk("line9 black", count_pat(8'h80, 8'h10), 2 * H_ACTIVE);
    chk("line9 underrun sticky", underrun, 1'b1);
    en = 1'b1;

    wait_pos(11, H_TOTAL - 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl line%0d eav", tbl[i].line), obs_eav[tbl[i].line], tbl[i].eav);
      chk($sformatf("tbl line%0d sav", tbl[i].line), obs_sav[tbl[i].line], tbl[i].sav);
      chk($sformatf("tbl line%0d f", tbl[i].line), obs_f[tbl[i].line], tbl[i].f);
      chk($sformatf("tbl line%0d v", tbl[i].line), obs_v[tbl[i].line], tbl[i].v);
    end

    wait_pos(0, H_TOTAL - 1);
    chk("wrap eav xy", cap[3], 8'hB6);
    chk("wrap sav xy", cap[A0 - 1], 8'hAB);

    wait_pos(3, 900);
    rst = 1'b1;
    #1;
    chk("midline reset data", td_data, 8'h80);
    chk("midline reset line", line_no, 10'd0);
    chk("midline reset underrun", underrun, 1'b0);
    chk("midline reset req", req, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_pos(0, 3);
    ex = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) chk($sformatf("restart byte%0d", i), cap[i], ex[i]);
    chk("restart line", line_no, 10'd0);

    wait_pos(2, H_TOTAL - 1);
    chk("restart line2 reqs", count_reqs(), H_ACTIVE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/itu656_encoder.md
Name: itu656_encoder

Overview:
- Generates an 8-bit ITU-R BT.656 byte stream from a YCbCr 4:2:2 pixel source, using the same byte format that the on-board video decoder path consumes.
- Produces the EAV/SAV timing codes, horizontal and vertical blanking, field/line counting, and a pull request toward an upstream pixel FIFO.
- Used as a loopback/test-pattern source for the capture chain and as the output stage for recorded surveillance video.

Parameters:
- H_ACTIVE, 720: active pixels per line; a line carries 2*H_ACTIVE active bytes.
- H_TOTAL, 1716: total bytes per line. Legal only if H_TOTAL >= 2*H_ACTIVE+8.
- V_TOTAL, 525: lines per frame, numbered 0..V_TOTAL-1.
- FIELD2_START, 263: first line of field 2; F=1 for lines >= FIELD2_START.
- V_BLANK, 20: V=1 for the first V_BLANK lines of each field, i.e. lines 0..V_BLANK-1 and FIELD2_START..FIELD2_START+V_BLANK-1.

Ports:
- iCLK_27  in  1  27 MHz byte clock.
- iRST  in  1  asynchronous, active-high reset.
- iEN  in  1  active-video enable; sampled only at line start.
- iYCbCr  in  16  [15:8]=Y, [7:0]=Cb for even pixel index and Cr for odd pixel index (ordering is upstream's job); valid the cycle after oREQ.
- iVALID  in  1  qualifies iYCbCr on the cycle after oREQ.
- oTD_DATA  out  8  BT.656 byte stream.
- oTD_HS  out  1  H bit, aligned with oTD_DATA.
- oTD_VS  out  1  V bit, aligned with oTD_DATA.
- oFIELD  out  1  F bit, aligned with oTD_DATA.
- oLINE  out  10  line number of the current byte.
- oREQ  out  1  pixel request, one-cycle pulse.
- oUNDERRUN  out  1  sticky flag: a requested word was missing.

Behaviour:
- Reset (async assert, iRST=1):
  - oTD_DATA=0x80; oTD_HS, oTD_VS, oFIELD, oREQ, oUNDERRUN = 0; oLINE=0.
  - Byte counter b=0, line counter=0, latched enable=0.
- Byte counter b runs 0..H_TOTAL-1. On wrap, the line counter increments mod V_TOTAL.
- All outputs are registered. The byte selected from b at edge t appears after edge t. The first edge after reset release drives 0xFF (b=0).
- Line layout, with A0 = H_TOTAL-2*H_ACTIVE:
  - b=0..3: EAV = FF 00 00 XY, with H=1.
  - b=4..A0-5: blanking, alternating 0x80 (even b) and 0x10 (odd b).
  - b=A0-4..A0-1: SAV = FF 00 00 XY, with H=0.
  - b=A0..H_TOTAL-1: active bytes, index a=b-A0.
- XY byte: bit7=1, bit6=F, bit5=V, bit4=H, bit3=V^H, bit2=F^H, bit1=F^V, bit0=F^V^H.
- oTD_HS=1 for b<A0 (covers EAV, blanking and SAV). oTD_VS=V; oFIELD=F.
- Lines with V=1: active region carries the blanking pattern (0x80/0x10) and no oREQ is issued.
- iEN is latched at b=0 of each line; mid-line changes are ignored until the next line.
- Active region with V=0 and latched enable=1:
  - Pixel p (0..H_ACTIVE-1) occupies a=2p (chroma) and a=2p+1 (Y).
  - oREQ pulses in the output cycle of byte b=A0+2p-2; for p=0 this lands in SAV byte 3 of 4.
  - iYCbCr/iVALID are sampled on the next edge.
  - Exactly H_ACTIVE pulses per active line, at most every other cycle.
- Active region with latched enable=0: black (chroma 0x80, Y 0x10) and no oREQ.
- Underrun: if iVALID=0 on a sample cycle, that pixel is emitted as chroma 0x80 / Y 0x10 and oUNDERRUN sets. It clears only on reset.
- Clamping: active bytes equal to 0x00 become 0x01, and 0xFF become 0xFE. Timing codes are never clamped.
- Reset mid-line: output returns immediately to its reset values. After release, generation restarts at b=0, line 0, with no partial pixel emitted.

Test Plan:
- Reset release, defaults:
  - Bytes 0..3 = FF 00 00 B6 (F=0, V=1, H=1).
  - Byte 4 = 0x80, byte 5 = 0x10.
  - SAV at b=272..275 = FF 00 00 AB.
  - No oREQ on line 0.
- Line 20, iEN=1, iVALID=1, iYCbCr=16'h5A3C constant:
  - SAV = FF 00 00 80.
  - Active bytes alternate 3C,5A, 1440 bytes total.
  - 720 oREQ pulses; the first is coincident with SAV byte 0x00 at b=274.
  - Following EAV XY = 9D.
- Line 283 (field 2 active): EAV XY = DA, SAV XY = C7, oFIELD=1. The frame wraps after line 524 back to line 0 with XY=B6.
- Data clamping: iYCbCr=16'hFF00 yields active bytes 01,FE repeating.
- Underrun: iVALID=0 for pixel 5 only.
  - Bytes a=10,11 = 80,10; all other pixels unchanged.
  - oUNDERRUN=1 and stays 1 across later lines.
- Enable and reset timing:
  - iEN toggled 1→0 at b=800: the current line stays live; the next line is black with no oREQ.
  - iRST pulsed at b=900 of line 30: immediate 0x80 output; restart at FF, line 0.
